// File: rtl/ar_access_sequencer.sv
// ar_access_sequencer: arbitrates instruction fetch and data access onto the
// address register and memory port. Loads AR, strobes memory until ready or
// timeout, then returns a one-cycle done pulse to the winning requester.
module ar_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic Clk,
  input  logic Rst,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  input  logic mem_ready,
  output logic WEN,
  output logic selAR,
  output logic mem_rd,
  output logic mem_wr,
  output logic fetch_done,
  output logic data_done,
  output logic err,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Last ACCESS cycle allowed before the operation is aborted with err.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic             grant_reg;       // 1 = fetch owns the operation, 0 = data
  logic             last_grant_reg;  // requester served most recently, same encoding
  logic             we_reg;          // direction captured at grant
  logic [CNT_W-1:0] cnt_reg;

  // Registered outputs, updated together with the state so they stay Moore.
  logic wen_reg;
  logic sel_reg;
  logic rd_reg;
  logic wr_reg;
  logic fetch_done_reg;
  logic data_done_reg;
  logic err_reg;
  logic busy_reg;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  logic pick_fetch;
  assign pick_fetch = fetch_req & (~data_req | ~last_grant_reg);

  // Sequencer FSM with its registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;   // data counts as served last, so fetch wins first
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      wen_reg        <= 1'b0;
      sel_reg        <= 1'b0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      fetch_done_reg <= 1'b0;
      data_done_reg  <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      // Single-cycle pulses default low and are raised only on their transition.
      wen_reg        <= 1'b0;
      fetch_done_reg <= 1'b0;
      data_done_reg  <= 1'b0;
      err_reg        <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (fetch_req || data_req) begin
            grant_reg <= pick_fetch;
            we_reg    <= pick_fetch ? 1'b0 : data_we;
            wen_reg   <= 1'b1;
            sel_reg   <= pick_fetch;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          cnt_reg   <= '0;
          rd_reg    <= ~we_reg;
          wr_reg    <= we_reg;
          state_reg <= ACCESS;
        end

        ACCESS: begin
          if (mem_ready || (cnt_reg == CNT_LAST)) begin
            // Ready on the final allowed cycle still counts as success.
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            fetch_done_reg <= grant_reg;
            data_done_reg  <= ~grant_reg;
            err_reg        <= ~mem_ready;
            last_grant_reg <= grant_reg;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RESP: begin
          sel_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign WEN        = wen_reg;
  assign selAR      = sel_reg;
  assign mem_rd     = rd_reg;
  assign mem_wr     = wr_reg;
  assign fetch_done = fetch_done_reg;
  assign data_done  = data_done_reg;
  assign err        = err_reg;
  assign busy       = busy_reg;

endmodule
